// File: rtl/mdio_pkg.sv
// mdio_pkg
// Shared definitions for the Clause-22 MDIO PHY responder: opcode values,
// register indices that get special treatment, and the frame FSM encoding.
package mdio_pkg;

    localparam logic [1:0] OP_READ  = 2'b10;
    localparam logic [1:0] OP_WRITE = 2'b01;

    localparam logic [4:0] REG_CTRL = 5'd0;
    localparam logic [4:0] REG_ID1  = 5'd2;
    localparam logic [4:0] REG_ID2  = 5'd3;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ST,
        S_OP,
        S_PHYAD,
        S_REGAD,
        S_TA,
        S_DATA
    } mdio_state_t;

endpackage

// File: rtl/mdio_sync_edge.sv
// mdio_sync_edge
// Two-flop synchronizer for a pin that is asynchronous to clk, followed by
// one edge-history flop so that single-cycle rise/fall pulses can be formed.
// Ports:
//   clk, reset_n : system clock, asynchronous active-low reset
//   din          : asynchronous input pin
//   level        : synchronized level of din
//   rise, fall   : one-clk pulses on a synchronized 0->1 / 1->0 transition
module mdio_sync_edge (
    input  logic clk,
    input  logic reset_n,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);

    // sync_sh[1:0] is the synchronizer; sync_sh[2] holds the previous level.
    logic [2:0] sync_sh;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_sh <= 3'b000;
        end else begin
            sync_sh <= {sync_sh[1:0], din};
        end
    end

    assign level = sync_sh[1];
    assign rise  = sync_sh[1] & ~sync_sh[2];
    assign fall  = ~sync_sh[1] & sync_sh[2];

endmodule

// File: rtl/mdio_phy_responder.sv
// mdio_phy_responder
// Clause-22 MDIO management responder (PHY side). MDC/MDIO are oversampled on
// clk, frames addressed to PHY_ADDR are decoded, and a 32 x 16-bit register
// file is served. MDIO is driven through an active-low output enable.
// Ports:
//   clk, reset_n   : system clock, asynchronous active-low reset
//   mdc, mdio_in   : management clock and MDIO pin value from the MAC side
//   mdio_out       : MDIO drive value
//   mdio_oen       : MDIO output enable, active low (0 = drive)
//   reg_wr_valid   : one-clk pulse per accepted register write
//   reg_wr_addr    : register index of that write
//   reg_wr_data    : data of that write
module mdio_phy_responder
    import mdio_pkg::*;
#(
    parameter logic [4:0]  PHY_ADDR     = 5'd1,
    parameter logic [15:0] PHY_ID1      = 16'h0141,
    parameter logic [15:0] PHY_ID2      = 16'h0CC2,
    parameter logic [15:0] REG0_DEFAULT = 16'h1140,
    parameter int          PREAMBLE_LEN = 32
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        mdc,
    input  logic        mdio_in,
    output logic        mdio_out,
    output logic        mdio_oen,
    output logic        reg_wr_valid,
    output logic [4:0]  reg_wr_addr,
    output logic [15:0] reg_wr_data
);

    localparam logic [5:0] PRE_MAX = PREAMBLE_LEN[5:0];

    logic mdc_rise, mdc_fall, mdc_level_unused;
    logic mdio_bit, mdio_rise_unused, mdio_fall_unused;

    mdio_state_t state, state_next;
    logic [5:0]  pre_cnt;
    logic [3:0]  bit_cnt;
    logic        op_msb;
    logic        is_read;
    logic        addr_match;
    logic [3:0]  phyad_sh;
    logic [4:0]  regad;
    logic [14:0] data_sh;
    logic [15:0] regs [32];
    logic [15:0] rd_data;
    logic        wr_fire;
    logic [15:0] wr_word;

    mdio_sync_edge u_mdc_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .din     (mdc),
        .level   (mdc_level_unused),
        .rise    (mdc_rise),
        .fall    (mdc_fall)
    );

    // Only the level of MDIO matters; it is sampled on mdc_rise.
    mdio_sync_edge u_mdio_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .din     (mdio_in),
        .level   (mdio_bit),
        .rise    (mdio_rise_unused),
        .fall    (mdio_fall_unused)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Field sequencing: every transition happens on a sampled MDC rising edge.
    always_comb begin
        state_next = state;
        if (mdc_rise) begin
            case (state)
                S_IDLE:  if (!mdio_bit && pre_cnt >= PRE_MAX) state_next = S_ST;
                S_ST:    state_next = mdio_bit ? S_OP : S_IDLE;
                S_OP: begin
                    if (bit_cnt == 4'd1) begin
                        if ({op_msb, mdio_bit} == OP_READ || {op_msb, mdio_bit} == OP_WRITE)
                            state_next = S_PHYAD;
                        else
                            state_next = S_IDLE;
                    end
                end
                S_PHYAD: if (bit_cnt == 4'd4)  state_next = S_REGAD;
                S_REGAD: if (bit_cnt == 4'd4)  state_next = S_TA;
                S_TA:    if (bit_cnt == 4'd1)  state_next = S_DATA;
                S_DATA:  if (bit_cnt == 4'd15) state_next = S_IDLE;
                default: state_next = S_IDLE;
            endcase
        end
    end

    assign wr_word = {data_sh, mdio_bit};
    assign wr_fire = mdc_rise && (state == S_DATA) && (bit_cnt == 4'd15) && !is_read && addr_match;

    // Read view: ID registers are constants, and the self-clearing soft-reset
    // bit of the control register always reads back as 0.
    always_comb begin
        rd_data = regs[regad];
        if (regad == REG_ID1)       rd_data = PHY_ID1;
        else if (regad == REG_ID2)  rd_data = PHY_ID2;
        else if (regad == REG_CTRL) rd_data = {1'b0, regs[0][14:0]};
    end

    // Frame datapath: counters and field shift registers advance on mdc_rise,
    // the MDIO driver changes only on mdc_fall.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pre_cnt      <= 6'd0;
            bit_cnt      <= 4'd0;
            op_msb       <= 1'b0;
            is_read      <= 1'b0;
            addr_match   <= 1'b0;
            phyad_sh     <= 4'd0;
            regad        <= 5'd0;
            data_sh      <= 15'd0;
            mdio_out     <= 1'b0;
            mdio_oen     <= 1'b1;
            reg_wr_valid <= 1'b0;
            reg_wr_addr  <= 5'd0;
            reg_wr_data  <= 16'd0;
        end else begin
            reg_wr_valid <= 1'b0;
            if (mdc_rise) begin
                bit_cnt <= (state_next != state) ? 4'd0 : bit_cnt + 4'd1;
                case (state)
                    S_IDLE: begin
                        if (mdio_bit) begin
                            if (pre_cnt < PRE_MAX) pre_cnt <= pre_cnt + 6'd1;
                        end else begin
                            pre_cnt <= 6'd0;
                        end
                    end
                    S_OP: begin
                        op_msb <= mdio_bit;
                        if (bit_cnt == 4'd1) is_read <= ({op_msb, mdio_bit} == OP_READ);
                    end
                    S_PHYAD: begin
                        phyad_sh <= {phyad_sh[2:0], mdio_bit};
                        if (bit_cnt == 4'd4) addr_match <= ({phyad_sh, mdio_bit} == PHY_ADDR);
                    end
                    S_REGAD: regad <= {regad[3:0], mdio_bit};
                    S_DATA: begin
                        data_sh <= {data_sh[13:0], mdio_bit};
                        if (wr_fire) begin
                            reg_wr_valid <= 1'b1;
                            reg_wr_addr  <= regad;
                            reg_wr_data  <= wr_word;
                        end
                    end
                    default: ;
                endcase
            end
            if (mdc_fall) begin
                if (state == S_TA && bit_cnt == 4'd1 && is_read && addr_match) begin
                    mdio_oen <= 1'b0;
                    mdio_out <= 1'b0;
                end else if (state == S_DATA && is_read && addr_match) begin
                    mdio_oen <= 1'b0;
                    mdio_out <= rd_data[~bit_cnt];
                end else begin
                    mdio_oen <= 1'b1;
                    mdio_out <= 1'b0;
                end
            end
        end
    end

    // Register file. A control write with bit 15 set reloads every register
    // to its default instead of storing the written value.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 32; i++) regs[i] <= (i == 0) ? REG0_DEFAULT : 16'h0000;
        end else if (wr_fire) begin
            if (regad == REG_CTRL && wr_word[15]) begin
                for (int i = 0; i < 32; i++) regs[i] <= (i == 0) ? REG0_DEFAULT : 16'h0000;
            end else if (regad != REG_ID1 && regad != REG_ID2) begin
                regs[regad] <= wr_word;
            end
        end
    end

endmodule

// File: tb/tb_mdio_phy_responder.sv
// tb_mdio_phy_responder
// Directed bench for the MDIO PHY responder: a MAC-side frame generator with a
// pulled-up MDIO pin model, and hand-computed expected values.
module tb_mdio_phy_responder;

    logic        clk;
    logic        reset_n;
    logic        mdc;
    logic        mdio_in;
    logic        mdio_out;
    logic        mdio_oen;
    logic        reg_wr_valid;
    logic [4:0]  reg_wr_addr;
    logic [15:0] reg_wr_data;

    logic        mac_val;
    logic        mac_oe;

    int compared;
    int mismatched;

    logic        smp_oen, smp_out;
    logic        cap_ta1_oen, cap_ta2_oen, cap_ta2_out, after_oen, abort_pre_oen;
    logic [15:0] rd_word;
    int          data_drv_cnt;
    logic        drove;
    int          wr_count;
    logic [4:0]  wr_addr_seen;
    logic [15:0] wr_data_seen;

    mdio_phy_responder dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .mdc          (mdc),
        .mdio_in      (mdio_in),
        .mdio_out     (mdio_out),
        .mdio_oen     (mdio_oen),
        .reg_wr_valid (reg_wr_valid),
        .reg_wr_addr  (reg_wr_addr),
        .reg_wr_data  (reg_wr_data)
    );

    // Shared MDIO line with a pull-up: PHY drive wins when enabled.
    assign mdio_in = (!mdio_oen) ? mdio_out : (mac_oe ? mac_val : 1'b1);

    initial clk = 1'b0;
    always #10 clk = ~clk;

    // Bus watchers: any PHY drive, and every clk where the write strobe is high.
    always @(negedge clk) begin
        if (mdio_oen === 1'b0) drove = 1'b1;
        if (reg_wr_valid === 1'b1) begin
            wr_count     = wr_count + 1;
            wr_addr_seen = reg_wr_addr;
            wr_data_seen = reg_wr_data;
        end
    end

    task automatic checkOutput(input string tag, input logic [15:0] observed, input logic [15:0] expected);
        compared++;
        assert (observed === expected) else begin
            mismatched++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Low phase of one MDC bit: MAC sets MDIO, then the PHY pin is sampled.
    task automatic bitLow(input logic b, input logic oe);
        @(negedge clk);
        mdc     = 1'b0;
        mac_val = b;
        mac_oe  = oe;
        repeat (5) @(negedge clk);
        smp_oen = mdio_oen;
        smp_out = mdio_out;
    endtask

    task automatic bitHigh();
        mdc = 1'b1;
        repeat (5) @(negedge clk);
    endtask

    task automatic sendBit(input logic b, input logic oe);
        bitLow(b, oe);
        bitHigh();
    endtask

    // One frame: guard 0 (clears any stray preamble count), preamble, ST=01,
    // OP, PHYAD, REGAD, TA, DATA, then one released idle bit. Read-type
    // opcodes leave TA and DATA to the PHY. abort_idx >= 0 asserts reset
    // during that data bit (0 = D15).
    task automatic applyStimulus(input int pre_len, input logic [1:0] op, input logic [4:0] phyad,
                                 input logic [4:0] regad, input logic [15:0] wdata, input int abort_idx);
        logic mac_drives;
        mac_drives   = (op == 2'b01);
        drove        = 1'b0;
        wr_count     = 0;
        data_drv_cnt = 0;
        rd_word      = 16'h0000;
        sendBit(1'b0, 1'b1);
        for (int i = 0; i < pre_len; i++) sendBit(1'b1, 1'b1);
        sendBit(1'b0, 1'b1);
        sendBit(1'b1, 1'b1);
        sendBit(op[1], 1'b1);
        sendBit(op[0], 1'b1);
        for (int i = 4; i >= 0; i--) sendBit(phyad[i], 1'b1);
        for (int i = 4; i >= 0; i--) sendBit(regad[i], 1'b1);
        bitLow(1'b1, mac_drives);
        cap_ta1_oen = smp_oen;
        bitHigh();
        bitLow(1'b0, mac_drives);
        cap_ta2_oen = smp_oen;
        cap_ta2_out = smp_out;
        bitHigh();
        for (int i = 0; i < 16; i++) begin
            bitLow(wdata[15-i], mac_drives);
            rd_word[15-i] = smp_out;
            if (smp_oen == 1'b0) data_drv_cnt++;
            if (i == abort_idx) begin
                abort_pre_oen = smp_oen;
                reset_n = 1'b0;
                #1;
                checkOutput("abort_oen_immediate", {15'd0, mdio_oen}, 16'h0001);
                mac_oe = 1'b0;
                return;
            end
            bitHigh();
        end
        bitLow(1'b1, 1'b0);
        after_oen = smp_oen;
        bitHigh();
    endtask

    initial begin
        compared   = 0;
        mismatched = 0;
        reset_n    = 1'b0;
        mdc        = 1'b0;
        mac_val    = 1'b1;
        mac_oe     = 1'b0;
        drove      = 1'b0;
        wr_count   = 0;
        abort_pre_oen = 1'b1;
        repeat (5) @(negedge clk);
        reset_n = 1'b1;
        repeat (3) @(negedge clk);
        $display("[TB] reset values");
        checkOutput("rst_oen",   {15'd0, mdio_oen},     16'h0001);
        checkOutput("rst_out",   {15'd0, mdio_out},     16'h0000);
        checkOutput("rst_valid", {15'd0, reg_wr_valid}, 16'h0000);
        checkOutput("rst_addr",  {11'd0, reg_wr_addr},  16'h0000);
        checkOutput("rst_data",  reg_wr_data,           16'h0000);

        $display("[TB] read PHY ID1");
        applyStimulus(32, 2'b10, 5'd1, 5'd2, 16'h0000, -1);
        checkOutput("id1_ta1_oen", {15'd0, cap_ta1_oen}, 16'h0001);
        checkOutput("id1_ta2_oen", {15'd0, cap_ta2_oen}, 16'h0000);
        checkOutput("id1_ta2_out", {15'd0, cap_ta2_out}, 16'h0000);
        checkOutput("id1_data",    rd_word,              16'h0141);
        checkOutput("id1_drv_cnt", data_drv_cnt[15:0],   16'd16);
        checkOutput("id1_after",   {15'd0, after_oen},   16'h0001);

        $display("[TB] write reg 4 then read back");
        applyStimulus(32, 2'b01, 5'd1, 5'd4, 16'hA5C3, -1);
        checkOutput("wr4_count", wr_count[15:0],        16'd1);
        checkOutput("wr4_addr",  {11'd0, wr_addr_seen}, 16'd4);
        checkOutput("wr4_data",  wr_data_seen,          16'hA5C3);
        checkOutput("wr4_drove", {15'd0, drove},        16'h0000);
        applyStimulus(32, 2'b10, 5'd1, 5'd4, 16'h0000, -1);
        checkOutput("rd4_data",  rd_word,               16'hA5C3);

        $display("[TB] other PHY address");
        applyStimulus(32, 2'b01, 5'd7, 5'd5, 16'hFFFF, -1);
        checkOutput("mis_wr_count", wr_count[15:0], 16'd0);
        applyStimulus(32, 2'b10, 5'd7, 5'd2, 16'h0000, -1);
        checkOutput("mis_rd_drove", {15'd0, drove}, 16'h0000);
        applyStimulus(32, 2'b10, 5'd1, 5'd3, 16'h0000, -1);
        checkOutput("id2_data", rd_word, 16'h0CC2);

        $display("[TB] short preamble and bad opcode");
        applyStimulus(31, 2'b10, 5'd1, 5'd2, 16'h0000, -1);
        checkOutput("short_drove", {15'd0, drove}, 16'h0000);
        applyStimulus(31, 2'b01, 5'd1, 5'd6, 16'h5555, -1);
        checkOutput("short_wr_count", wr_count[15:0], 16'd0);
        applyStimulus(32, 2'b11, 5'd1, 5'd4, 16'h0000, -1);
        checkOutput("badop_drove", {15'd0, drove}, 16'h0000);
        checkOutput("badop_wr_count", wr_count[15:0], 16'd0);
        applyStimulus(32, 2'b10, 5'd1, 5'd4, 16'h0000, -1);
        checkOutput("after_badop_rd4", rd_word, 16'hA5C3);

        $display("[TB] writes to ID register and soft reset");
        applyStimulus(32, 2'b01, 5'd1, 5'd2, 16'hDEAD, -1);
        checkOutput("wr_id1_count", wr_count[15:0], 16'd1);
        applyStimulus(32, 2'b10, 5'd1, 5'd2, 16'h0000, -1);
        checkOutput("id1_unchanged", rd_word, 16'h0141);
        applyStimulus(32, 2'b01, 5'd1, 5'd4, 16'h1234, -1);
        checkOutput("wr4b_data", wr_data_seen, 16'h1234);
        applyStimulus(32, 2'b01, 5'd1, 5'd0, 16'h8000, -1);
        checkOutput("wr0_addr", {11'd0, wr_addr_seen}, 16'd0);
        checkOutput("wr0_data", wr_data_seen,          16'h8000);
        applyStimulus(32, 2'b10, 5'd1, 5'd0, 16'h0000, -1);
        checkOutput("rd0_default", rd_word, 16'h1140);
        applyStimulus(32, 2'b10, 5'd1, 5'd4, 16'h0000, -1);
        checkOutput("rd4_cleared", rd_word, 16'h0000);

        $display("[TB] reset during read data");
        applyStimulus(32, 2'b01, 5'd1, 5'd9, 16'h3C3C, -1);
        applyStimulus(32, 2'b10, 5'd1, 5'd2, 16'h0000, 7);
        checkOutput("abort_pre_oen", {15'd0, abort_pre_oen}, 16'h0000);
        repeat (5) @(negedge clk);
        reset_n = 1'b1;
        repeat (5) @(negedge clk);
        applyStimulus(32, 2'b10, 5'd1, 5'd2, 16'h0000, -1);
        checkOutput("post_abort_id1", rd_word, 16'h0141);
        applyStimulus(32, 2'b10, 5'd1, 5'd9, 16'h0000, -1);
        checkOutput("post_abort_rd9", rd_word, 16'h0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
